// File: rtl/matmul_mac_stage.sv
// Signed multiply-accumulate stage for the matmul core. It forms length-K dot products
// from the A/B BRAM read stream and writes each result to the output BRAM.
module matmul_mac_stage #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int K      = 8,
  parameter int N_OUT  = 64,
  parameter int OUT_AW = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              res_we,
  output logic              res_en,
  output logic [OUT_AW-1:0] res_addr,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              done
);

  localparam int PW = 2 * DATA_W;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [RD_LAT-1:0]       vld_pipe;
  logic                    p_vld;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic [KW-1:0]           k_cnt;
  logic [OUT_AW-1:0]       out_cnt;

  logic                    run;
  logic                    d_vld;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic                    k_last;
  logic                    out_last;

  assign run   = (state == S_RUN);
  assign d_vld = vld_pipe[RD_LAT-1];

  // Operands widened to the full product width so the low PW bits form the exact signed product.
  assign a_ext    = {{DATA_W{a_data[DATA_W-1]}}, a_data};
  assign b_ext    = {{DATA_W{b_data[DATA_W-1]}}, b_data};
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // The first element of each dot product restarts the sum instead of adding to the old one.
  assign acc_next = (k_cnt == '0) ? prod_ext : acc + prod_ext;
  assign k_last   = (k_cnt == KW'(K - 1));
  assign out_last = (out_cnt == OUT_AW'(N_OUT - 1));

  // Read-valid delay line and product register. Reads are accepted only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      p_vld    <= 1'b0;
      prod     <= '0;
    end else if (start) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values and the
      // delay line shifts by exactly one stage per clock regardless of statement order.
      vld_pipe <= '0;
      p_vld    <= 1'b0;
    end else begin
      vld_pipe[0] <= en_rd && run;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      p_vld <= d_vld && run;
      if (d_vld) begin
        prod <= a_ext * b_ext;
      end
    end
  end

  // Control FSM, accumulator and registered BRAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
      k_cnt    <= '0;
      out_cnt  <= '0;
      res_we   <= 1'b0;
      res_en   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_we <= 1'b0;
      res_en <= 1'b0;
      if (start) begin
        state   <= S_RUN;
        busy    <= 1'b1;
        done    <= 1'b0;
        k_cnt   <= '0;
        out_cnt <= '0;
      end else if (p_vld && run) begin
        acc <= acc_next;
        if (k_last) begin
          k_cnt    <= '0;
          res_data <= acc_next;
          res_addr <= out_cnt;
          res_we   <= 1'b1;
          res_en   <= 1'b1;
          out_cnt  <= out_cnt + 1'b1;
          if (out_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_mac_stage.sv
// Directed bench for matmul_mac_stage: a BRAM read model feeds the stage and a
// scoreboard of expected writes is drained by a monitor on the falling clock edge.
module tb_matmul_mac_stage;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int K      = 8;
  localparam int N_OUT  = 64;
  localparam int OUT_AW = 12;
  localparam int RD_LAT = 1;

  typedef struct {
    logic signed [ACC_W-1:0] data;
    int                      addr;
    int                      cyc;
    bit                      last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              en_rd = 1'b0;
  logic [DATA_W-1:0] a_data = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic [DATA_W-1:0] a_req = '0;
  logic [DATA_W-1:0] b_req = '0;
  logic              res_we;
  logic              res_en;
  logic [OUT_AW-1:0] res_addr;
  logic [ACC_W-1:0]  res_data;
  logic              busy;
  logic              done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Reference model state
  logic signed [ACC_W-1:0] m_sum;
  int                      m_k;
  int                      m_out;
  bit                      m_run;

  matmul_mac_stage #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .K(K), .N_OUT(N_OUT), .OUT_AW(OUT_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_rd(en_rd),
    .a_data(a_data), .b_data(b_data),
    .res_we(res_we), .res_en(res_en), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency BRAM: data requested with en_rd appears after the next edge.
  always @(posedge clk) begin
    a_data <= a_req;
    b_data <= b_req;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Write monitor: every res_we pops one expected result.
  always @(negedge clk) begin
    if (rst_n && res_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_write", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", $signed(res_data), e.data);
        check("res_addr", res_addr, e.addr);
        check("res_latency", cyc, e.cyc);
        check("res_en", res_en, 1);
        check("done_at_write", done, e.last);
        check("busy_at_write", busy, !e.last);
      end
    end
  end

  task automatic do_start(input bit with_rd);
    @(negedge clk);
    start = 1'b1;
    en_rd = with_rd;
    a_req = 8'd5;
    b_req = 8'd5;
    m_sum = '0;
    m_k   = 0;
    m_out = 0;
    m_run = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_rd = 1'b0;
  endtask

  task automatic elem(input int a, input int b);
    exp_t e;
    @(negedge clk);
    en_rd = 1'b1;
    a_req = DATA_W'(a);
    b_req = DATA_W'(b);
    if (m_run) begin
      m_sum = m_sum + ACC_W'(a * b);
      m_k++;
      if (m_k == K) begin
        e.data = m_sum;
        e.addr = m_out;
        e.cyc  = cyc + RD_LAT + 2;
        m_out++;
        e.last = (m_out == N_OUT);
        sb.push_back(e);
        m_k   = 0;
        m_sum = '0;
        if (m_out == N_OUT) m_run = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_rd = 1'b0;
    end
  endtask

  initial begin
    m_sum = '0; m_k = 0; m_out = 0; m_run = 1'b0;

    // Power-on reset state
    #12;
    check("rst_res_we", res_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mid-run while a write is on the port, en_rd toggling throughout
    do_start(1'b0);
    for (int i = 1; i <= 2 * K; i++) elem(3, i);
    idle(RD_LAT + 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_res_we", res_we, 0);
    check("arst_res_en", res_en, 0);
    check("arst_res_addr", res_addr, 0);
    check("arst_res_data", $signed(res_data), 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    m_run = 1'b0; m_k = 0; m_sum = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en_rd = i[0];
    end
    @(negedge clk);
    en_rd = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) elem(7, 7);
    idle(4);
    check("idle_busy", busy, 0);
    check("idle_no_writes", sb.size(), 0);

    // 2 + 3: single dot, then signed extremes
    do_start(1'b0);
    check("start_busy", busy, 1);
    for (int i = 1; i <= K; i++) elem(i, 1);
    for (int i = 0; i < K; i++) elem(-128, -128);
    for (int i = 0; i < K; i++) elem(-128, 127);
    idle(RD_LAT + 4);
    check("sgn_drained", sb.size(), 0);

    // 4: full run of contiguous reads, then extra reads after completion
    do_start(1'b0);
    for (int i = 0; i < N_OUT * K; i++) elem(1, 1);
    idle(RD_LAT + 3);
    check("full_done", done, 1);
    check("full_busy", busy, 0);
    for (int i = 0; i < 20; i++) elem(2, 3);
    idle(5);
    check("after_done_addr", res_addr, N_OUT - 1);
    check("after_done_held", done, 1);
    check("full_drained", sb.size(), 0);

    // 5: same stream with random 1-3 cycle bubbles
    do_start(1'b0);
    for (int i = 0; i < N_OUT * K; i++) begin
      elem(1, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(RD_LAT + 3);
    check("bub_done", done, 1);
    check("bub_drained", sb.size(), 0);

    // 6: restart after element 5 of dot 3; the read on the start cycle is discarded
    do_start(1'b0);
    check("rs_done_cleared", done, 0);
    for (int d = 0; d < 3; d++)
      for (int i = 1; i <= K; i++) elem(i, d + 1);
    for (int i = 1; i <= 5; i++) elem(9, 9);
    do_start(1'b1);
    check("rs_busy", busy, 1);
    check("rs_done", done, 0);
    for (int i = 1; i <= K; i++) elem(i, -2);
    idle(RD_LAT + 4);
    check("rs_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
